// File: rtl/pll_divgen.sv
// pll_divgen: NUM_CH divided, phase-aligned clocks from clkin with tick strobes and a lock flag.
// Optional macro PLL_DIVGEN_RELOCK_EN: run-time reconfiguration relocks and realigns all channels.
module pll_divgen #(
   parameter int NUM_CH      = 2,
   parameter int DIV_W       = 8,
   parameter int LOCK_CYCLES = 8,
   parameter int DEFAULT_DIV = 1,
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clkin,
   input  logic              rst_n,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic [DIV_W-1:0]  cfg_phase,
   output logic [NUM_CH-1:0] clkout,
   output logic [NUM_CH-1:0] tick,
   output logic              locked
);
   localparam int LC_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   localparam logic [LC_W-1:0] LOCK_LAST = LC_W'(LOCK_CYCLES - 1);

   localparam logic [1:0] ST_RST  = 2'd0;
   localparam logic [1:0] ST_LOCK = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

   function automatic logic [DIV_W-1:0] fix_div(input logic [DIV_W-1:0] d);
      return (d == '0) ? DIV_W'(1) : d;
   endfunction

   // An out-of-range phase would never reach the wrap point, so it starts from zero instead.
   function automatic logic [DIV_W:0] start_cnt(input logic [DIV_W-1:0] d, input logic [DIV_W-1:0] p);
      return ({1'b0, p} >= {d, 1'b0}) ? '0 : {1'b0, p};
   endfunction

   logic [1:0]        state;
   logic [LC_W-1:0]   lock_cnt;
   logic [DIV_W-1:0]  div      [NUM_CH];
   logic [DIV_W-1:0]  phase    [NUM_CH];
   logic [DIV_W:0]    cnt      [NUM_CH];
   logic [DIV_W-1:0]  div_nx   [NUM_CH];
   logic [DIV_W-1:0]  phase_nx [NUM_CH];
   logic [NUM_CH-1:0] wrap;
   logic              pending;
   logic              accept;
   logic              ch_ok;
   logic              direct_wr;
   logic              relock;

   assign cfg_ready = (state != ST_RST) && !pending;
   assign accept    = cfg_valid && cfg_ready;
   assign ch_ok     = ({1'b0, cfg_ch} < (CH_W+1)'(NUM_CH));

`ifdef PLL_DIVGEN_RELOCK_EN
   assign relock    = accept && ch_ok && (state == ST_RUN);
   assign direct_wr = accept && ch_ok && (state != ST_RST);
   assign pending   = 1'b0;
`else
   logic [CH_W-1:0]  sh_ch;
   logic [DIV_W-1:0] sh_div;

   assign relock    = 1'b0;
   assign direct_wr = accept && ch_ok && (state == ST_LOCK);

   // Run-time updates wait in one shadow slot until the target channel completes its period.
   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         pending <= 1'b0;
      end else if (accept && ch_ok && (state == ST_RUN)) begin
         pending <= 1'b1;
      end else if (pending && wrap[sh_ch]) begin
         pending <= 1'b0;
      end
   end

   always_ff @(posedge clkin) begin
      if (accept && ch_ok && (state == ST_RUN)) begin
         sh_ch  <= cfg_ch;
         sh_div <= fix_div(cfg_div);
      end
   end
`endif

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         div_nx[i]   = div[i];
         phase_nx[i] = phase[i];
         if (direct_wr && (cfg_ch == CH_W'(i))) begin
            div_nx[i]   = fix_div(cfg_div);
            phase_nx[i] = cfg_phase;
         end
`ifndef PLL_DIVGEN_RELOCK_EN
         if (pending && wrap[i] && (sh_ch == CH_W'(i))) begin
            div_nx[i] = sh_div;
         end
`endif
      end
   end

   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_RST;
         lock_cnt <= '0;
         locked   <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            div[i]   <= fix_div(DIV_W'(DEFAULT_DIV));
            phase[i] <= '0;
            cnt[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            div[i]   <= div_nx[i];
            phase[i] <= phase_nx[i];
         end
         case (state)
            ST_RST: begin
               state    <= ST_LOCK;
               lock_cnt <= '0;
            end
            ST_LOCK: begin
               if (lock_cnt == LOCK_LAST) begin
                  state  <= ST_RUN;
                  locked <= 1'b1;
                  for (int i = 0; i < NUM_CH; i++) begin
                     cnt[i] <= start_cnt(div_nx[i], phase_nx[i]);
                  end
               end else begin
                  lock_cnt <= lock_cnt + LC_W'(1);
               end
            end
            ST_RUN: begin
               if (relock) begin
                  state    <= ST_LOCK;
                  locked   <= 1'b0;
                  lock_cnt <= '0;
               end else begin
                  for (int i = 0; i < NUM_CH; i++) begin
                     cnt[i] <= wrap[i] ? '0 : cnt[i] + (DIV_W+1)'(1);
                  end
               end
            end
            default: begin
               state  <= ST_RST;
               locked <= 1'b0;
            end
         endcase
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_out
      assign wrap[i]   = (cnt[i] == ({div[i], 1'b0} - (DIV_W+1)'(1)));
      assign clkout[i] = locked && (cnt[i] < {1'b0, div[i]});
      assign tick[i]   = locked && (cnt[i] == '0);
   end
endmodule
